// File: rtl/main_button_pio_irq_pkg.sv
// -----------------------------------------------------------------------------
// main_button_pkg
// Shared definitions for the multi-channel push-button PIO: register word
// offsets seen on the Avalon-MM slave and the edge-capture mode encodings.
// -----------------------------------------------------------------------------
package main_button_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_RSVD    = 2'd1,
    REG_IRQMASK = 2'd2,
    REG_EDGECAP = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/main_button_pio_irq_if.sv
// -----------------------------------------------------------------------------
// main_button_pio_irq_if
// Avalon-MM slave register bus for the push-button PIO.
//   address    : register word offset
//   chipselect : slave select, qualifies writes
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
interface main_button_pio_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/main_button_pio_irq_debounce.sv
// -----------------------------------------------------------------------------
// main_button_debounce
// One button channel: SYNC_STAGES-deep synchroniser followed by a counter
// debouncer. The debounced level only follows the synchronised input after it
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_raw       : raw asynchronous button input
//   deb_o        : debounced level
// -----------------------------------------------------------------------------
module main_button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw,
  output logic deb_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
    cnt_d  = '0;
    deb_d  = deb_q;
    if (sync_out != deb_q) begin
      // Final disagreeing cycle: adopt the new level and restart the count.
      if (cnt_q == CNT_LAST) deb_d = sync_out;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt_q  <= '0;
      deb_q  <= IDLE_LEVEL;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/main_button_pio_irq.sv
// -----------------------------------------------------------------------------
// main_button_pio_irq
// Multi-channel push-button PIO with debouncing, per-channel edge capture,
// interrupt mask and a registered level irq.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (DATA / reserved / IRQMASK / EDGECAPTURE)
//   in_port      : raw asynchronous button inputs
//   irq          : level interrupt, high while any unmasked capture bit is set
// -----------------------------------------------------------------------------
module main_button_pio_irq
  import main_button_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int EDGE_MODE       = EDGE_FALL
) (
  input  logic                  clk,
  input  logic                  reset_n,
  main_button_pio_irq_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] deb_lvl;
  logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] rise, fall, edge_set, clr;
  logic             wr_en;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    main_button_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .in_raw (in_port[g]),
      .deb_o  (deb_lvl[g])
    );
  end

  assign wr_en = bus.chipselect & ~bus.write_n;

  always_comb begin
    deb_dly_d = deb_lvl;
    rise      = deb_lvl & ~deb_dly_q;
    fall      = ~deb_lvl & deb_dly_q;
    if (EDGE_MODE == EDGE_RISE)      edge_set = rise;
    else if (EDGE_MODE == EDGE_FALL) edge_set = fall;
    else                             edge_set = rise | fall;

    mask_d = mask_q;
    clr    = '0;
    if (wr_en && bus.address == REG_IRQMASK) mask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == REG_EDGECAP) clr    = bus.writedata[WIDTH-1:0];
    // A new edge overrides a simultaneous clear of the same bit.
    edgecap_d = (edgecap_q & ~clr) | edge_set;

    readdata_d = '0;
    case (reg_addr_e'(bus.address))
      REG_DATA:    readdata_d[WIDTH-1:0] = deb_lvl;
      REG_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
      REG_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:     readdata_d = '0;
    endcase

    irq_d = |(edgecap_q & mask_q);
  end

  // The delayed copy resets to the idle level so reset release never looks
  // like a transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_dly_q  <= {WIDTH{IDLE_LEVEL}};
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      deb_dly_q  <= deb_dly_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
